// File: rtl/axis_load_sweep_ctrl.sv
// Offered-load sweep sequencer for a NoC ring traffic harness: for each load-table
// entry it resets the harness, starts the generators, waits for drain or timeout and reports.
module axis_load_sweep_ctrl #(
  parameter int          NUM_ROUTERS    = 4,
  parameter int          COUNT_WIDTH    = 32,
  parameter int          LOAD_WIDTH     = 16,
  parameter int          NUM_LOADS      = 8,
  parameter int          TICK_WIDTH     = 32,
  parameter int          RESET_CYCLES   = 6,
  parameter int          START_DELAY    = 5,
  parameter int          FLUSH_CYCLES   = 3,
  parameter logic [63:0] TIMEOUT_CYCLES = 64'h0000_0000_8000_0000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               go,
  input  logic                               abort,
  input  logic [$clog2(NUM_LOADS+1)-1:0]     num_loads,
  input  logic [NUM_LOADS*LOAD_WIDTH-1:0]    load_table,
  input  logic [NUM_ROUTERS-1:0]             tg_done,
  input  logic [NUM_ROUTERS*COUNT_WIDTH-1:0] total_sent,
  input  logic [NUM_ROUTERS*COUNT_WIDTH-1:0] total_recv,
  input  logic [NUM_ROUTERS-1:0]             chk_error,
  output logic                               harness_rst_n,
  output logic [NUM_ROUTERS-1:0]             start,
  output logic [LOAD_WIDTH-1:0]              load,
  output logic [TICK_WIDTH-1:0]              ticks,
  output logic                               busy,
  output logic                               result_valid,
  output logic [$clog2(NUM_LOADS)-1:0]       result_idx,
  output logic [TICK_WIDTH-1:0]              result_cycles,
  output logic                               result_timeout,
  output logic [NUM_ROUTERS-1:0]             result_errors,
  output logic                               sweep_done,
  output logic [2:0]                         dbg_state
);

  localparam int NW = $clog2(NUM_LOADS + 1);
  localparam int IW = $clog2(NUM_LOADS);
  localparam int CW = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    REPORT  = 3'd4,
    FLUSH   = 3'd5
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          idx_next;
  logic [NW-1:0]          n_loads;
  logic                   abort_seen;
  logic [NUM_ROUTERS-1:0] err_acc;

  logic [COUNT_WIDTH-1:0] sum_sent_c;
  logic [COUNT_WIDTH-1:0] sum_recv_c;
  logic [COUNT_WIDTH-1:0] sum_sent_q;
  logic [COUNT_WIDTH-1:0] sum_recv_q;
  logic                   all_done;
  logic                   all_done_q;
  logic                   point_ok;
  logic                   point_timeout;
  logic                   last_point;

  // Protocol: go is a single-cycle request accepted only in IDLE (no ready);
  // result_valid and sweep_done are single-cycle strobes with no back-pressure.

  always_comb begin
    sum_sent_c = '0;
    sum_recv_c = '0;
    for (int i = 0; i < NUM_ROUTERS; i++) begin
      sum_sent_c = sum_sent_c + total_sent[i*COUNT_WIDTH +: COUNT_WIDTH];
      sum_recv_c = sum_recv_c + total_recv[i*COUNT_WIDTH +: COUNT_WIDTH];
    end
  end

  // The registered sums must themselves have been sampled while every TG was done,
  // otherwise a late packet counted in the same cycle as done could be missed.
  assign all_done      = &tg_done;
  assign point_ok      = all_done && all_done_q && (sum_sent_q == sum_recv_q);
  assign point_timeout = 64'(ticks) >= TIMEOUT_CYCLES;
  assign last_point    = (NW'(idx) + NW'(1)) == n_loads;
  assign idx_next      = idx + IW'(1);
  assign dbg_state     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      n_loads        <= '0;
      abort_seen     <= 1'b0;
      err_acc        <= '0;
      sum_sent_q     <= '0;
      sum_recv_q     <= '0;
      all_done_q     <= 1'b0;
      harness_rst_n  <= 1'b0;
      start          <= '0;
      load           <= '0;
      ticks          <= '0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_idx     <= '0;
      result_cycles  <= '0;
      result_timeout <= 1'b0;
      result_errors  <= '0;
      sweep_done     <= 1'b0;
    end else begin
      sum_sent_q   <= sum_sent_c;
      sum_recv_q   <= sum_recv_c;
      all_done_q   <= all_done;
      result_valid <= 1'b0;
      sweep_done   <= 1'b0;

      if (state != IDLE && abort) abort_seen <= 1'b1;
      if (state inside {RELEASE, RUN, REPORT, FLUSH}) ticks <= ticks + TICK_WIDTH'(1);

      case (state)
        IDLE: begin
          harness_rst_n <= 1'b0;
          busy          <= 1'b0;
          start         <= '0;
          if (go) begin
            if (num_loads == '0) begin
              sweep_done <= 1'b1;
            end else begin
              n_loads    <= num_loads;
              idx        <= '0;
              abort_seen <= 1'b0;
              load       <= load_table[0 +: LOAD_WIDTH];
              ticks      <= '0;
              cnt        <= '0;
              busy       <= 1'b1;
              state      <= HOLD;
            end
          end
        end

        HOLD: begin
          ticks <= '0;
          if (cnt == CW'(RESET_CYCLES - 1)) begin
            cnt           <= '0;
            harness_rst_n <= 1'b1;
            state         <= RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RELEASE: begin
          if (cnt == CW'(START_DELAY - 1)) begin
            cnt     <= '0;
            start   <= '1;
            err_acc <= '0;
            state   <= RUN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RUN: begin
          err_acc <= err_acc | chk_error;
          start   <= start & ~tg_done;
          if (point_timeout || point_ok) begin
            result_valid   <= 1'b1;
            result_idx     <= idx;
            result_cycles  <= ticks;
            result_timeout <= point_timeout;
            result_errors  <= err_acc | chk_error;
            start          <= '0;
            state          <= REPORT;
          end
        end

        REPORT: begin
          cnt   <= '0;
          state <= FLUSH;
        end

        FLUSH: begin
          if (cnt == CW'(FLUSH_CYCLES - 1)) begin
            cnt           <= '0;
            harness_rst_n <= 1'b0;
            if (abort_seen || abort || last_point) begin
              busy       <= 1'b0;
              sweep_done <= 1'b1;
              state      <= IDLE;
            end else begin
              idx   <= idx_next;
              load  <= load_table[idx_next*LOAD_WIDTH +: LOAD_WIDTH];
              ticks <= '0;
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_load_sweep_ctrl.sv
// Bench for axis_load_sweep_ctrl: a behavioural TG harness drives each point and a
// monitor compares every result strobe against records predicted from the point scenario.
module tb_axis_load_sweep_ctrl;

  localparam int NR           = 4;
  localparam int CWD          = 32;
  localparam int LW           = 16;
  localparam int NL           = 8;
  localparam int TW           = 32;
  localparam int RESET_CYCLES = 6;
  localparam int START_DELAY  = 5;
  localparam int FLUSH_CYCLES = 3;
  localparam int TIMEOUT      = 1000;
  localparam int REC_W        = 3 + LW + TW + 1 + NR;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              go = 1'b0;
  logic              abort = 1'b0;
  logic [3:0]        num_loads = '0;
  logic [NL*LW-1:0]  load_table = '0;
  logic [NR-1:0]     tg_done = '0;
  logic [NR*CWD-1:0] total_sent = '0;
  logic [NR*CWD-1:0] total_recv = '0;
  logic [NR-1:0]     chk_error = '0;

  logic              harness_rst_n;
  logic [NR-1:0]     start;
  logic [LW-1:0]     load;
  logic [TW-1:0]     ticks;
  logic              busy;
  logic              result_valid;
  logic [2:0]        result_idx;
  logic [TW-1:0]     result_cycles;
  logic              result_timeout;
  logic [NR-1:0]     result_errors;
  logic              sweep_done;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  axis_load_sweep_ctrl #(
    .NUM_ROUTERS(NR), .COUNT_WIDTH(CWD), .LOAD_WIDTH(LW), .NUM_LOADS(NL),
    .TICK_WIDTH(TW), .RESET_CYCLES(RESET_CYCLES), .START_DELAY(START_DELAY),
    .FLUSH_CYCLES(FLUSH_CYCLES), .TIMEOUT_CYCLES(64'd1000)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .num_loads(num_loads),
    .load_table(load_table), .tg_done(tg_done), .total_sent(total_sent),
    .total_recv(total_recv), .chk_error(chk_error), .harness_rst_n(harness_rst_n),
    .start(start), .load(load), .ticks(ticks), .busy(busy),
    .result_valid(result_valid), .result_idx(result_idx),
    .result_cycles(result_cycles), .result_timeout(result_timeout),
    .result_errors(result_errors), .sweep_done(sweep_done), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [REC_W-1:0] exp_q[$];

  // Point scenarios: done delay per router (cycles after start), cycle at which
  // recv stops lagging sent by one, optional single error pulse.
  int          d_tab[NL][NR];
  int          r_tab[NL];
  int          ek_tab[NL];
  int          er_tab[NL];
  logic [31:0] sent_tab[NL][NR];
  logic [15:0] tbl[NL];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
  endtask

  // Reference: ticks is START_DELAY on the first start cycle; the point completes one
  // cycle after both "all done" and "sums equal" hold, else ticks saturates at TIMEOUT.
  function automatic logic [REC_W-1:0] model_point(input int p);
    int maxd = 0;
    int t;
    logic to;
    logic [31:0] cyc;
    logic [NR-1:0] err;
    logic [2:0] pi;
    for (int i = 0; i < NR; i++) if (d_tab[p][i] > maxd) maxd = d_tab[p][i];
    t = START_DELAY + ((maxd > r_tab[p]) ? maxd : r_tab[p]) + 1;
    if (t >= TIMEOUT) begin to = 1'b1; cyc = TIMEOUT; end
    else begin to = 1'b0; cyc = 32'(t); end
    err = (ek_tab[p] >= 0) ? (NR'(1) << er_tab[p]) : '0;
    pi = 3'(p);
    return {pi, tbl[p], cyc, to, err};
  endfunction

  // ---------------- monitor ----------------
  int cyc = 0;
  int hold_cnt = 0, rel_cyc = 0, last_rv_cyc = 0, res_since = 0, sd_cnt = 0, rise_cnt = 0;
  logic prev_rstn = 1'b0;
  logic [NR-1:0] prev_start = '0;
  logic [REC_W-1:0] mon_e;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      hold_cnt = 0; res_since = 0; prev_rstn = 1'b0; prev_start = '0;
    end else begin
      if (!busy) hold_cnt = 0;
      else if (!harness_rst_n) hold_cnt++;
      if (!prev_rstn && harness_rst_n) begin
        rise_cnt++;
        chk("reset_hold_len", 64'(hold_cnt), RESET_CYCLES);
        hold_cnt = 0;
        rel_cyc = cyc;
      end
      if (prev_start == '0 && start == '1) chk("start_delay", 64'(cyc - rel_cyc), START_DELAY);
      if (result_valid) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("result_idx", 64'(result_idx), 64'(mon_e[REC_W-1 -: 3]));
          chk("result_load", 64'(load), 64'(mon_e[REC_W-4 -: LW]));
          chk("result_cycles", 64'(result_cycles), 64'(mon_e[NR+TW : NR+1]));
          chk("result_timeout", 64'(result_timeout), 64'(mon_e[NR]));
          chk("result_errors", 64'(result_errors), 64'(mon_e[NR-1:0]));
        end
        last_rv_cyc = cyc;
        res_since++;
      end
      if (sweep_done) begin
        sd_cnt++;
        chk("results_outstanding", 64'(exp_q.size()), 0);
        if (res_since > 0) chk("sweep_done_lag", 64'(cyc - last_rv_cyc), FLUSH_CYCLES + 1);
        res_since = 0;
      end
      prev_rstn  = harness_rst_n;
      prev_start = start;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    tg_done = '0; chk_error = '0; total_sent = '0; total_recv = '0; abort = 1'b0; go = 1'b0;
  endtask

  task automatic drive_point(input int p, input int k, input int abort_pt, input bit go_busy);
    for (int i = 0; i < NR; i++) begin
      tg_done[i] = (k >= d_tab[p][i]);
      total_sent[i*CWD +: CWD] = sent_tab[p][i];
      total_recv[i*CWD +: CWD] = (i == 0 && k < r_tab[p]) ? sent_tab[p][i] - 32'd1 : sent_tab[p][i];
    end
    chk_error = (k == ek_tab[p]) ? (NR'(1) << er_tab[p]) : '0;
    abort     = (p == abort_pt) && (k == 3);
    go        = go_busy && (k == 2);
  endtask

  task automatic pulse_go(input int n);
    @(posedge clk); #1;
    num_loads = 4'(n);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic run_point(input int p, input int abort_pt, input bit go_busy);
    bit seen = 1'b0;
    bit got = 1'b0;
    bit start_ok = 1'b1;
    int k = 0;
    for (int w = 0; w < 300 && !seen; w++) begin
      @(posedge clk); #1;
      if (start == '1) seen = 1'b1;
    end
    chk("start_seen", 64'(seen), 1);
    if (seen) begin
      while (!got && k < 1200) begin
        for (int i = 0; i < NR; i++) if (start[i] !== (k <= d_tab[p][i])) start_ok = 1'b0;
        drive_point(p, k, abort_pt, go_busy);
        @(posedge clk); #1;
        k++;
        if (result_valid) got = 1'b1;
      end
      chk("result_seen", 64'(got), 1);
      chk("start_drop", 64'(start_ok), 1);
    end
    drive_idle();
  endtask

  task automatic run_sweep(input int n, input int abort_pt, input bit go_busy);
    int pts;
    int sd0;
    bit ok = 1'b0;
    pts = (abort_pt >= 0 && abort_pt < n) ? abort_pt + 1 : n;
    for (int p = 0; p < NL; p++) load_table[p*LW +: LW] = tbl[p];
    for (int p = 0; p < pts; p++) exp_q.push_back(model_point(p));
    sd0 = sd_cnt;
    pulse_go(n);
    for (int p = 0; p < pts; p++) run_point(p, abort_pt, go_busy);
    for (int w = 0; w < 50 && !ok; w++) begin
      @(posedge clk); #1;
      if (sd_cnt != sd0) ok = 1'b1;
    end
    chk("sweep_done_seen", 64'(ok), 1);
    chk("idle_busy", 64'(busy), 0);
  endtask

  task automatic fill_random(input int p, input int dmin);
    int maxd = 0;
    tbl[p] = 16'($urandom_range(65535, 0));
    for (int i = 0; i < NR; i++) begin
      d_tab[p][i] = int'($urandom_range(60, dmin));
      if (d_tab[p][i] > maxd) maxd = d_tab[p][i];
      sent_tab[p][i] = $urandom();
    end
    r_tab[p]  = ($urandom_range(9, 0) == 0) ? 3000 : int'($urandom_range(70, 0));
    ek_tab[p] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(maxd, 0)) : -1;
    er_tab[p] = int'($urandom_range(NR - 1, 0));
  endtask

  task automatic set_fixed(input int p, input logic [15:0] ld, input int d0, input int d1,
                           input int d2, input int d3, input int r);
    tbl[p] = ld;
    d_tab[p][0] = d0; d_tab[p][1] = d1; d_tab[p][2] = d2; d_tab[p][3] = d3;
    for (int i = 0; i < NR; i++) sent_tab[p][i] = 32'd25;
    r_tab[p] = r;
    ek_tab[p] = -1;
    er_tab[p] = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rises;
    bit seen;
    for (int p = 0; p < NL; p++) fill_random(p, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_harness_rst_n", 64'(harness_rst_n), 0);
    chk("rst_start", 64'(start), 0);
    chk("rst_load", 64'(load), 0);
    chk("rst_ticks", 64'(ticks), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_result_valid", 64'(result_valid), 0);
    chk("rst_result_idx", 64'(result_idx), 0);
    chk("rst_result_cycles", 64'(result_cycles), 0);
    chk("rst_result_timeout", 64'(result_timeout), 0);
    chk("rst_result_errors", 64'(result_errors), 0);
    chk("rst_sweep_done", 64'(sweep_done), 0);
    rst = 1'b0;

    // normal point: done 200 cycles after start, sums 100/100
    set_fixed(0, 16'd655, 200, 200, 200, 200, 0);
    run_sweep(1, -1, 1'b0);

    // staggered done
    set_fixed(0, 16'd1234, 10, 20, 30, 40, 0);
    run_sweep(1, -1, 1'b0);

    // sum lag: all done immediately, recv one short for 50 cycles
    set_fixed(0, 16'd4321, 0, 0, 0, 0, 50);
    run_sweep(1, -1, 1'b0);

    // timeout on point 0, sweep continues to point 1
    set_fixed(0, 16'd777, 3, 5, 7, 9, 5000);
    fill_random(1, 0);
    r_tab[1] = 20;
    run_sweep(2, -1, 1'b0);

    // three points, error pulse on router 2 during point 1, stray go while busy
    for (int p = 0; p < 3; p++) fill_random(p, 5);
    ek_tab[0] = -1; ek_tab[2] = -1;
    ek_tab[1] = 3;  er_tab[1] = 2;
    r_tab[0] = 10; r_tab[1] = 10; r_tab[2] = 10;
    run_sweep(3, -1, 1'b1);

    // reset in the middle of RUN, then restart from idx 0
    for (int p = 0; p < NL; p++) load_table[p*LW +: LW] = tbl[p];
    pulse_go(3);
    seen = 1'b0;
    for (int w = 0; w < 100 && !seen; w++) begin
      @(posedge clk); #1;
      if (start == '1) seen = 1'b1;
    end
    chk("midrst_start_seen", 64'(seen), 1);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_harness_rst_n", 64'(harness_rst_n), 0);
    chk("midrst_start", 64'(start), 0);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_ticks", 64'(ticks), 0);
    chk("midrst_load", 64'(load), 0);
    chk("midrst_result_valid", 64'(result_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int p = 0; p < 2; p++) fill_random(p, 0);
    run_sweep(2, -1, 1'b0);

    // abort during point 0 of 3
    for (int p = 0; p < 3; p++) fill_random(p, 10);
    run_sweep(3, 0, 1'b0);

    // go with num_loads=0
    rises = rise_cnt;
    run_sweep(0, -1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("zero_loads_no_release", 64'(rise_cnt - rises), 0);

    // random sweeps
    for (int s = 0; s < 4; s++) begin
      int n;
      n = int'($urandom_range(NL, 1));
      for (int p = 0; p < n; p++) fill_random(p, 0);
      run_sweep(n, -1, 1'b0);
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running(state %0d) required=finished", dbg_state);
    $fatal(1, "watchdog expired");
  end

endmodule
